// File: rtl/router_pkt_reg.sv
// rtl/router_pkt_reg.sv - router input packet register with parity/length check and stall holding queue
module router_pkt_reg #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int HOLD_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              write_enb,
    output logic [ADDR_W-1:0] dest_addr,
    output logic              parity_done,
    output logic              err,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int QCNT_W = $clog2(HOLD_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, parity_q, parity_d;
    logic [LEN_W-1:0]  len_q, len_d, pay_cnt_q, pay_cnt_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              pd_q, pd_d, err_q, err_d, len_err_q, len_err_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;

    logic [DATA_W-1:0] mem_q [HOLD_DEPTH];
    logic [PTR_W-1:0]  rd_q, wr_q;
    logic [QCNT_W-1:0] qcnt_q;
    logic [DATA_W-1:0] dout_q;
    logic              we_q;
    logic              push, pop, accept;

    assign busy   = (qcnt_q == QCNT_W'(HOLD_DEPTH));
    assign accept = !busy && (state_q != S_CHECK);
    assign pop    = (qcnt_q != '0) && !fifo_full;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        parity_d  = parity_q;
        len_d     = len_q;
        pay_cnt_d = pay_cnt_q;
        dest_d    = dest_q;
        pd_d      = pd_q;
        err_d     = err_q;
        len_err_d = len_err_q;
        ecnt_d    = ecnt_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid && accept) begin
                    push      = 1'b1;
                    dest_d    = data_in[ADDR_W-1:0];
                    len_d     = data_in[DATA_W-1:ADDR_W];
                    acc_d     = data_in;
                    pay_cnt_d = '0;
                    pd_d      = 1'b0;
                    err_d     = 1'b0;
                    len_err_d = 1'b0;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    push = 1'b1;
                    if (pkt_valid) begin
                        acc_d = acc_q ^ data_in;
                        if (pay_cnt_q != '1)
                            pay_cnt_d = pay_cnt_q + LEN_W'(1);
                    end else begin
                        parity_d = data_in;
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // A saturated payload counter means the true length is unknown, so it always flags.
                err_d     = (acc_q != parity_q);
                len_err_d = (pay_cnt_q != len_q) || (pay_cnt_q == '1);
                pd_d      = 1'b1;
                if ((err_d || len_err_d) && (ecnt_q != '1))
                    ecnt_d = ecnt_q + CNT_W'(1);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            parity_q  <= '0;
            len_q     <= '0;
            pay_cnt_q <= '0;
            dest_q    <= '0;
            pd_q      <= 1'b0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            parity_q  <= parity_d;
            len_q     <= len_d;
            pay_cnt_q <= pay_cnt_d;
            dest_q    <= dest_d;
            pd_q      <= pd_d;
            err_q     <= err_d;
            len_err_q <= len_err_d;
            ecnt_q    <= ecnt_d;
        end
    end

    // Storage needs no reset: the occupancy count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_q] <= data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            qcnt_q <= '0;
            dout_q <= '0;
            we_q   <= 1'b0;
        end else begin
            if (push)
                wr_q <= (wr_q == PTR_W'(HOLD_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            if (pop) begin
                rd_q   <= (rd_q == PTR_W'(HOLD_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
                dout_q <= mem_q[rd_q];
            end
            if (push && !pop)
                qcnt_q <= qcnt_q + QCNT_W'(1);
            else if (pop && !push)
                qcnt_q <= qcnt_q - QCNT_W'(1);
            we_q <= pop;
        end
    end

    assign dout        = dout_q;
    assign write_enb   = we_q;
    assign dest_addr   = dest_q;
    assign parity_done = pd_q;
    assign err         = err_q;
    assign len_err     = len_err_q;
    assign err_count   = ecnt_q;

endmodule
